alu_exec_stage: RTL

Execute-stage ALU that consumes the 4-bit `ALUOperation` code from the ALU control decoder together with two 32-bit operands and a shift amount. It produces a registered 32-bit result, a Zero flag and an Invalid flag, with a start/busy/done handshake. Logical and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, unless the barrel-shift option is compiled in. It sits between the register-file/immediate operand muxes and the write-back/branch logic.

---
 rtl/alu_exec_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with start/busy/done handshake and registered result/flags.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts iterate one bit per cycle.
module alu_exec_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  ALUOperation,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [4:0]  shamt,
   output logic        busy,
   output logic        done,
   output logic [31:0] ALUResult,
   output logic        Zero,
   output logic        Invalid
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state, state_nxt;
   logic [31:0] sreg, sreg_step, comb_res;
   logic [4:0]  cnt;
   logic        dir;
   logic        is_shift, is_valid, accept, go_shift, shift_last;

   always_comb begin
      is_shift = (ALUOperation[3:1] == 3'b011);
      is_valid = ~ALUOperation[3];
      comb_res = 32'h0;
      case (ALUOperation)
         4'b0000: comb_res = A & B;
         4'b0001: comb_res = A | B;
         4'b0010: comb_res = ~(A | B);
         4'b0011: comb_res = A + B;
         4'b0100: comb_res = A - B;
         4'b0101: comb_res = {B[15:0], 16'h0000};
`ifdef ALU_BARREL_SHIFT_EN
         4'b0110: comb_res = B << shamt;
         4'b0111: comb_res = B >> shamt;
`else
         // Only reached here with shamt==0; nonzero amounts go through SHIFT.
         4'b0110: comb_res = B;
         4'b0111: comb_res = B;
`endif
         default: comb_res = 32'h0;
      endcase
   end

   assign accept     = start && (state == IDLE);
`ifdef ALU_BARREL_SHIFT_EN
   assign go_shift   = 1'b0;
`else
   assign go_shift   = accept && is_shift && (shamt != 5'd0);
`endif
   assign shift_last = (state == SHIFT) && (cnt == 5'd1);
   assign sreg_step  = dir ? (sreg >> 1) : (sreg << 1);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go_shift)   state_nxt = SHIFT;
         SHIFT:   if (shift_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
   end

   // Result and flags move only on completion edges or reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sreg      <= 32'h0;
         cnt       <= 5'd0;
         dir       <= 1'b0;
         done      <= 1'b0;
         ALUResult <= 32'h0;
         Zero      <= 1'b1;
         Invalid   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (go_shift) begin
            sreg <= B;
            cnt  <= shamt;
            dir  <= ALUOperation[0];
         end else if (accept) begin
            ALUResult <= comb_res;
            Zero      <= (comb_res == 32'h0);
            Invalid   <= ~is_valid;
            done      <= 1'b1;
         end else if (state == SHIFT) begin
            sreg <= sreg_step;
            cnt  <= cnt - 5'd1;
            if (shift_last) begin
               ALUResult <= sreg_step;
               Zero      <= (sreg_step == 32'h0);
               Invalid   <= 1'b0;
               done      <= 1'b1;
            end
         end
      end
   end

endmodule
